// File: rtl/accel_sram_arbiter.sv
// Three-requester arbiter in front of a single-port SRAM; one access per 4 cycles (IDLE/ACCESS/WAIT/RESP).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority r0 > r1 > r2.
module accel_sram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [5:0]      req_op,
    input  logic [3*AW-1:0] req_addr,
    input  logic [3*DW-1:0] req_wdata,
    output logic [2:0]      done,
    output logic [DW-1:0]   rdata,
    output logic [1:0]      grant_id,
    output logic            busy,
    output logic            sram_en,
    output logic [3:0]      sram_we,
    output logic [AW-1:0]   sram_addr,
    output logic [DW-1:0]   sram_di,
    input  logic [DW-1:0]   sram_do
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            we_op_q, we_op_d;
    logic            sram_en_q, sram_en_d;
    logic [3:0]      sram_we_q, sram_we_d;
    logic [AW-1:0]   sram_addr_q, sram_addr_d;
    logic [DW-1:0]   sram_di_q, sram_di_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [2:0]      done_q, done_d;

    // Op codes 01 and 11 both have bit 0 set; 00 and 10 never request.
    logic [2:0] req_valid;
    logic       win_found;
    logic [1:0] win_id;

    assign req_valid = {req_op[4], req_op[2], req_op[0]};

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;

    function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // Scan from the farthest offset down so the requester nearest the pointer wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (req_valid[rr_idx(ptr_q, 2'(i))]) begin
                win_found = 1'b1;
                win_id    = rr_idx(ptr_q, 2'(i));
            end
        end
    end
`else
    always_comb begin
        win_found = |req_valid;
        if (req_valid[0]) begin
            win_id = 2'd0;
        end else if (req_valid[1]) begin
            win_id = 2'd1;
        end else begin
            win_id = 2'd2;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        we_op_d     = we_op_q;
        sram_en_d   = 1'b0;
        sram_we_d   = 4'b0000;
        sram_addr_d = sram_addr_q;
        sram_di_d   = sram_di_q;
        rdata_d     = rdata_q;
        done_d      = 3'b000;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = ACCESS;
                    grant_d     = win_id;
                    busy_d      = 1'b1;
                    we_op_d     = req_op[{win_id, 1'b1}];
                    sram_en_d   = 1'b1;
                    sram_we_d   = req_op[{win_id, 1'b1}] ? 4'b1111 : 4'b0000;
                    sram_addr_d = req_addr[AW*win_id +: AW];
                    sram_di_d   = req_wdata[DW*win_id +: DW];
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d       = rr_idx(win_id, 2'd1);
`endif
                end
            end
            ACCESS: begin
                state_d = WAIT;
            end
            // The SRAM read word is valid during WAIT, so it is captured on the edge leaving it.
            WAIT: begin
                state_d = RESP;
                if (!we_op_q) begin
                    rdata_d = sram_do;
                end
                case (grant_q)
                    2'd0:    done_d = 3'b001;
                    2'd1:    done_d = 3'b010;
                    default: done_d = 3'b100;
                endcase
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                grant_d = 2'd3;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            grant_q     <= 2'd3;
            busy_q      <= 1'b0;
            we_op_q     <= 1'b0;
            sram_en_q   <= 1'b0;
            sram_we_q   <= 4'b0000;
            sram_addr_q <= '0;
            sram_di_q   <= '0;
            rdata_q     <= '0;
            done_q      <= 3'b000;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            we_op_q     <= we_op_d;
            sram_en_q   <= sram_en_d;
            sram_we_q   <= sram_we_d;
            sram_addr_q <= sram_addr_d;
            sram_di_q   <= sram_di_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign done      = done_q;
    assign rdata     = rdata_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign sram_en   = sram_en_q;
    assign sram_we   = sram_we_q;
    assign sram_addr = sram_addr_q;
    assign sram_di   = sram_di_q;

endmodule

// File: tb/tb_accel_sram_arbiter.sv
// Scoreboard bench for accel_sram_arbiter: a transaction-level model predicts grant order, access and done timing, and read data.
// Follows ARB_ROUND_ROBIN_EN the same way as the design it is compiled with.
module tb_accel_sram_arbiter;

    typedef struct {
        int          id;
        bit          isWrite;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          accCycle;
        int          doneCycle;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [5:0]  reqOp;
    logic [23:0] reqAddr;
    logic [95:0] reqWdata;
    logic [2:0]  done;
    logic [31:0] rdata;
    logic [1:0]  grantId;
    logic        busy;
    logic        sramEn;
    logic [3:0]  sramWe;
    logic [7:0]  sramAddr;
    logic [31:0] sramDi;
    logic [31:0] sramDo;

    logic [31:0] sramMem  [256];
    logic [31:0] modelMem [256];
    logic [31:0] modelRdata;
    int          modelPtr;
    exp_t        expQ[$];
    exp_t        monE;
    int          cyc;
    int          checks;
    int          errors;

    accel_sram_arbiter #(.AW(8), .DW(32)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .req_op    (reqOp),
        .req_addr  (reqAddr),
        .req_wdata (reqWdata),
        .done      (done),
        .rdata     (rdata),
        .grant_id  (grantId),
        .busy      (busy),
        .sram_en   (sramEn),
        .sram_we   (sramWe),
        .sram_addr (sramAddr),
        .sram_di   (sramDi),
        .sram_do   (sramDo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port SRAM; outside enabled edges the read port shows garbage so mistimed captures are visible.
    always @(posedge clk) begin
        if (sramEn) begin
            sramDo <= sramMem[sramAddr];
            if (|sramWe) sramMem[sramAddr] <= sramDi;
        end else begin
            sramDo <= $urandom;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Issues one round of requests and queues the predicted service order of every valid requester.
    task automatic applyStimulus(input logic [5:0] op, input logic [23:0] addr, input logic [95:0] wd,
                                 output int nExp);
        bit [2:0] pend;
        int       pick;
        int       c0;
        exp_t     e;
        c0   = cyc;
        nExp = 0;
        for (int r = 0; r < 3; r++) pend[r] = op[2*r];
        while (pend != 3'b000) begin
            pick = -1;
`ifdef ARB_ROUND_ROBIN_EN
            for (int k = 0; k < 3; k++)
                if (pick < 0 && pend[(modelPtr + k) % 3]) pick = (modelPtr + k) % 3;
            modelPtr = (pick + 1) % 3;
`else
            for (int k = 2; k >= 0; k--)
                if (pend[k]) pick = k;
`endif
            e.id      = pick;
            e.isWrite = op[2*pick+1];
            e.addr    = addr[8*pick +: 8];
            e.wdata   = wd[32*pick +: 32];
            if (e.isWrite) modelMem[e.addr] = e.wdata;
            else           modelRdata = modelMem[e.addr];
            e.rdata     = modelRdata;
            e.accCycle  = c0 + 1 + 4*nExp;
            e.doneCycle = c0 + 3 + 4*nExp;
            expQ.push_back(e);
            pend[pick] = 1'b0;
            nExp++;
        end
        reqOp    = op;
        reqAddr  = addr;
        reqWdata = wd;
    endtask

    task automatic doReset();
        rst   = 1'b1;
        reqOp = 6'b000000;
        expQ.delete();
        modelPtr   = 0;
        modelRdata = 32'h0;
        #1;
        checkOutput("rst_done", done, 3'b000);
        checkOutput("rst_rdata", rdata, 32'h0);
        checkOutput("rst_grant", grantId, 2'd3);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_sram_en", sramEn, 1'b0);
        checkOutput("rst_sram_we", sramWe, 4'h0);
        checkOutput("rst_sram_addr", sramAddr, 8'h0);
        checkOutput("rst_sram_di", sramDi, 32'h0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_hold_done", done, 3'b000);
        end
        rst = 1'b0;
    endtask

    // Each requester drops its op in the cycle its done pulse is seen.
    task automatic waitDone(input int nExp);
        int got;
        int t;
        got = 0;
        t   = 0;
        if (nExp == 0) begin
            repeat (4) @(negedge clk);
        end else begin
            while (got < nExp && t < nExp*4 + 12) begin
                @(negedge clk);
                t++;
                for (int r = 0; r < 3; r++) begin
                    if (done[r] && reqOp[2*r]) begin
                        reqOp[2*r +: 2] = 2'b00;
                        got++;
                    end
                end
            end
            checkOutput("round_served", got, nExp);
            if (got < nExp) doReset();
        end
        reqOp = 6'b000000;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sramEn) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_access", sramEn, 1'b0);
                end else begin
                    monE = expQ[0];
                    checkOutput("acc_cycle", cyc, monE.accCycle);
                    checkOutput("acc_addr", sramAddr, monE.addr);
                    checkOutput("acc_we", sramWe, monE.isWrite ? 4'hF : 4'h0);
                    if (monE.isWrite) checkOutput("acc_di", sramDi, monE.wdata);
                    checkOutput("acc_grant", grantId, monE.id);
                    checkOutput("acc_busy", busy, 1'b1);
                end
            end
            if (done != 3'b000) begin
                checkOutput("done_onehot", $countones(done), 1);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", done, 3'b000);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("done_id", done, 64'd1 << monE.id);
                    checkOutput("done_rdata", rdata, monE.rdata);
                    checkOutput("done_cycle", cyc, monE.doneCycle);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [5:0]  op;
        logic [23:0] ad;
        logic [95:0] wd;
        int          v;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        reqOp    = 6'b000000;
        reqAddr  = 24'h0;
        reqWdata = 96'h0;
        for (int i = 0; i < 256; i++) begin
            sramMem[i]  = $urandom;
            modelMem[i] = sramMem[i];
        end
        sramMem[5]  = 32'h0000_002A;
        modelMem[5] = 32'h0000_002A;

        @(negedge clk);
        doReset();

        $display("[TB] single read r1 @0x05");
        applyStimulus(6'b000100, {8'h00, 8'h05, 8'h00}, 96'h0, n);
        waitDone(n);

        $display("[TB] single write r0 @0x10");
        applyStimulus(6'b000011, {8'h00, 8'h00, 8'h10}, {64'h0, 32'hDEAD_BEEF}, n);
        waitDone(n);

        $display("[TB] three-way contention");
        applyStimulus(6'b010101, {8'h10, 8'h05, 8'h10}, 96'h0, n);
        waitDone(n);

        $display("[TB] op 10 on r1 is never granted");
        reqOp = 6'b001000;
        repeat (10) begin
            @(negedge clk);
            checkOutput("inv_busy", busy, 1'b0);
            checkOutput("inv_sram_en", sramEn, 1'b0);
            checkOutput("inv_done", done, 3'b000);
        end
        reqOp = 6'b000000;
        @(negedge clk);

        $display("[TB] reset during WAIT of an r2 read");
        applyStimulus(6'b010000, {8'h33, 16'h0}, 96'h0, n);
        repeat (2) @(negedge clk);
        doReset();
        applyStimulus(6'b010101, {8'h33, 8'h05, 8'h10}, 96'h0, n);
        waitDone(n);

        $display("[TB] randomized rounds");
        for (int round = 0; round < 40; round++) begin
            for (int r = 0; r < 3; r++) begin
                v = $urandom_range(0, 3);
                op[2*r +: 2]  = (v == 0) ? 2'b00 : (v == 1) ? 2'b01 : (v == 2) ? 2'b10 : 2'b11;
                ad[8*r +: 8]  = 8'($urandom_range(0, 15));
                wd[32*r +: 32] = $urandom;
            end
            applyStimulus(op, ad, wd, n);
            waitDone(n);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        checkOutput("queue_empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
